// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: pin synchroniser, 3-sample majority filter and a baud tick
// generator that re-phases to mid-bit on every detected start-bit edge.
module uart_rx_frontend #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  input  logic enable,
  output logic rx_clean,
  output logic baud_tick,
  output logic frame_busy,
  output logic false_start
);

  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int HW  = $clog2(OVERSAMPLE);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [HW-1:0] PHASE_LAST = HW'(OVERSAMPLE - 1);
  localparam logic [HW-1:0] PHASE_MID  = HW'(OVERSAMPLE / 2 - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_frontend: clock divider DIV=%0d must be at least 2", DIV);
  end
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
    $error("uart_rx_frontend: OVERSAMPLE=%0d must be even and >= 4", OVERSAMPLE);
  end

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    RUN
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [PW-1:0] r_presc;
  logic [HW-1:0] r_phase;
  logic [2:0]    r_hist;
  logic          r_rx_clean;
  logic [3:0]    r_bit_cnt;
  logic          r_baud_tick;
  logic          r_frame_busy;
  logic          r_false_start;

  logic w_sample_tick;
  logic w_maj;
  logic w_fall;
  logic w_edge_hunt;
  logic w_btick;

  // Synchroniser keeps running regardless of enable so the line state is fresh on re-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample_tick = enable && (r_presc == PRESC_LAST);
  assign w_maj         = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
  assign w_fall        = w_sample_tick && r_rx_clean && !w_maj;
  assign w_edge_hunt   = w_fall && (r_state == HUNT);
  // A start edge in HUNT pre-empts a coincident free-running tick.
  assign w_btick       = w_sample_tick && (r_phase == PHASE_MID) && !w_edge_hunt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (!enable || (r_presc == PRESC_LAST)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist     <= 3'b111;
      r_rx_clean <= 1'b1;
    end else if (!enable) begin
      r_hist     <= 3'b111;
      r_rx_clean <= 1'b1;
    end else if (w_sample_tick) begin
      r_hist     <= {r_hist[1:0], r_sync2};
      r_rx_clean <= w_maj;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (!enable || w_edge_hunt) begin
      r_phase <= '0;
    end else if (w_sample_tick) begin
      r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + HW'(1);
    end
  end

  // Frame tracker; frame_busy is held through the stop-bit tick and drops one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_bit_cnt     <= 4'd0;
      r_baud_tick   <= 1'b0;
      r_frame_busy  <= 1'b0;
      r_false_start <= 1'b0;
    end else if (!enable) begin
      r_state       <= HUNT;
      r_bit_cnt     <= 4'd0;
      r_baud_tick   <= 1'b0;
      r_frame_busy  <= 1'b0;
      r_false_start <= 1'b0;
    end else begin
      r_baud_tick   <= w_btick;
      r_false_start <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_edge_hunt) begin
            r_state      <= VERIFY;
            r_bit_cnt    <= 4'd0;
            r_frame_busy <= 1'b1;
          end else begin
            r_frame_busy <= 1'b0;
          end
        end
        VERIFY: begin
          if (w_btick) begin
            if (!r_rx_clean) begin
              r_state   <= RUN;
              r_bit_cnt <= 4'd1;
            end else begin
              r_state       <= HUNT;
              r_frame_busy  <= 1'b0;
              r_false_start <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_btick) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd9) begin
              r_state <= HUNT;
            end
          end
        end
        default: begin
          r_state <= HUNT;
        end
      endcase
    end
  end

  assign rx_clean    = r_rx_clean;
  assign baud_tick   = r_baud_tick;
  assign frame_busy  = r_frame_busy;
  assign false_start = r_false_start;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: serial stimulus pushes the expected
// per-bit line values; a negedge monitor checks every tick and false start.
module tb_uart_rx_frontend;

  localparam int CLK_HZ     = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 160;
  localparam int TMIN       = 88;
  localparam int TMAX       = 108;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pin = 1'b1;
  logic enable = 1'b1;
  logic rx_clean, baud_tick, frame_busy, false_start;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    bit          is_fs;
    bit          val;
    int unsigned t0;
    int          k;
  } exp_t;

  exp_t sb[$];

  uart_rx_frontend #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_pin(rx_pin),
    .enable(enable),
    .rx_clean(rx_clean),
    .baud_tick(baud_tick),
    .frame_busy(frame_busy),
    .false_start(false_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one expectation per tick-in-frame or false_start pulse.
  exp_t m_e;
  int   m_dt;
  always @(negedge clk) begin
    if (!rst && baud_tick && frame_busy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: baud_tick at cycle %0d, required none", cyc);
      end else begin
        m_e = sb.pop_front();
        if (m_e.is_fs) begin
          errors++;
          $display("FAIL tick_order: baud_tick at cycle %0d, required false_start", cyc);
        end else begin
          if (rx_clean !== m_e.val) begin
            errors++;
            $display("FAIL bit_value k=%0d: rx_clean %0b, required %0b", m_e.k, rx_clean, m_e.val);
          end
          checks++;
          m_dt = int'(cyc) - int'(m_e.t0) - m_e.k * BIT_CLK;
          if (m_dt < TMIN || m_dt > TMAX) begin
            errors++;
            $display("FAIL tick_timing k=%0d: offset %0d clk, required %0d..%0d", m_e.k, m_dt, TMIN, TMAX);
          end
        end
      end
    end
    if (!rst && false_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL false_start_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        m_e = sb.pop_front();
        if (!m_e.is_fs) begin
          errors++;
          $display("FAIL false_start_order: pulse at cycle %0d, required tick for bit k=%0d", cyc, m_e.k);
        end
      end
    end
  end

  // Drives start/data/stop for nclk cycles; the first n_exp bits are expected as ticks.
  task automatic send_bits(input logic [7:0] d, input int n_exp, input int nclk);
    logic [9:0]  bits;
    int unsigned t0;
    bits = {1'b1, d, 1'b0};
    t0   = cyc;
    for (int k = 0; k < n_exp; k++) begin
      sb.push_back('{is_fs: 1'b0, val: bits[k], t0: t0, k: k});
    end
    for (int i = 0; i < nclk; i++) begin
      rx_pin = bits[i / BIT_CLK];
      wait_clk(1);
    end
  endtask

  task automatic glitch(input int len);
    int bad;
    bad = 0;
    for (int i = 0; i < len + 60; i++) begin
      rx_pin = (i < len) ? 1'b0 : 1'b1;
      wait_clk(1);
      if (rx_clean !== 1'b1 || frame_busy !== 1'b0) bad++;
    end
    check($sformatf("glitch_%0d_quiet", len), bad, 0);
  endtask

  task automatic false_start_pulse(input int len);
    bit seen;
    seen = 1'b0;
    sb.push_back('{is_fs: 1'b1, val: 1'b1, t0: cyc, k: 0});
    for (int i = 0; i < 200; i++) begin
      rx_pin = (i < len) ? 1'b0 : 1'b1;
      wait_clk(1);
      if (frame_busy === 1'b1) seen = 1'b1;
    end
    check($sformatf("false_start_%0d_busy_seen", len), seen, 1);
    check($sformatf("false_start_%0d_busy_after", len), frame_busy, 0);
  endtask

  task automatic wait_tick(output int unsigned t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      wait_clk(1);
      if (baud_tick === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  initial begin
    int unsigned t1, t2, t3;
    bit          ok1, ok2, ok3;
    logic [7:0]  d;
    int          sel;

    rst = 1'b1;
    enable = 1'b1;
    rx_pin = 1'b1;
    wait_clk(5);
    check("reset_rx_clean", rx_clean, 1);
    check("reset_baud_tick", baud_tick, 0);
    check("reset_frame_busy", frame_busy, 0);
    check("reset_false_start", false_start, 0);
    rst = 1'b0;

    wait_tick(t1, ok1);
    wait_tick(t2, ok2);
    wait_tick(t3, ok3);
    check("idle_ticks_found", {29'd0, ok1, ok2, ok3}, 7);
    check("idle_period_a", t2 - t1, BIT_CLK);
    check("idle_period_b", t3 - t2, BIT_CLK);

    send_bits(8'hA5, 10, 10 * BIT_CLK);
    wait_clk(100);

    glitch(5);
    false_start_pulse(30);

    send_bits(8'h00, 10, 10 * BIT_CLK);
    send_bits(8'hFF, 10, 10 * BIT_CLK);
    wait_clk(100);

    send_bits(8'h00, 5, 5 * BIT_CLK + 50);
    enable = 1'b0;
    rx_pin = 1'b1;
    wait_clk(1);
    check("enable_drop_tick", baud_tick, 0);
    check("enable_drop_busy", frame_busy, 0);
    wait_clk(300);
    check("disabled_rx_clean", rx_clean, 1);
    enable = 1'b1;
    wait_clk(50);
    send_bits(8'h3C, 10, 10 * BIT_CLK);
    wait_clk(100);

    send_bits(8'h00, 5, 5 * BIT_CLK + 50);
    check("rst_abort_busy_before", frame_busy, 1);
    check("rst_abort_rx_before", rx_clean, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rx_clean", rx_clean, 1);
    check("rst_async_baud_tick", baud_tick, 0);
    check("rst_async_frame_busy", frame_busy, 0);
    check("rst_async_false_start", false_start, 0);
    rx_pin = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(50);
    send_bits(8'h3C, 10, 10 * BIT_CLK);
    wait_clk(100);

    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1: begin
          d = 8'($urandom);
          send_bits(d, 10, 10 * BIT_CLK);
          wait_clk($urandom_range(0, 200));
        end
        2: glitch($urandom_range(1, 9));
        default: false_start_pulse($urandom_range(25, 60));
      endcase
    end

    wait_clk(300);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Receive-side front end for the UART. It synchronises and de-glitches the raw `rx_pin` and produces `rx_clean` plus a bit-rate `baud_tick`. The tick is re-phased to mid-bit on every start-bit falling edge, so the downstream bit-level receiver samples each bit at its centre. It sits between the device pin and the UART receiver, and both of its outputs feed that receiver directly.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115200: line bit rate.
- `OVERSAMPLE`, default 16: sample ticks per bit. Must be even and ≥ 4.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx_pin`  in  1: raw asynchronous serial input. Idle level is high.
- `enable`  in  1: 0 holds the block idle.
- `rx_clean`  out  1: filtered, synchronous serial data.
- `baud_tick`  out  1: one-clk pulse at mid-bit, once per bit period.
- `frame_busy`  out  1: high while a frame is being tracked.
- `false_start`  out  1: one-clk pulse when a start bit is rejected.

## Operation
- Derived constant `DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, which is rounded. `DIV < 2` is an elaboration error.
- Prescaler counts 0..DIV-1 and wraps. `sample_tick` is asserted for one clk when the count equals DIV-1.
- Synchroniser: two flops on `rx_pin`, both reset to 1.
- Filter:
  - On each `sample_tick`, shift the synchronised bit into a 3-bit history (reset 3'b111).
  - `rx_clean` takes the majority of the history on the same `sample_tick`.
  - A single-sample glitch never reaches `rx_clean`.
- Phase counter runs 0..OVERSAMPLE-1 on `sample_tick` and wraps. `baud_tick` pulses on the `sample_tick` at which the phase counter equals OVERSAMPLE/2-1.
- Falling edge = `rx_clean` changing 1→0 on a `sample_tick`.
- State machine:
  - **HUNT**:
    - Phase counter runs free, so `baud_tick` continues at bit rate while the line idles.
    - A falling edge clears the phase counter to 0 on that same `sample_tick` and moves to **VERIFY**.
  - **VERIFY** (on the first `baud_tick`, which is mid-start-bit):
    - If `rx_clean`=0: go to **RUN** with bit count = 1.
    - If `rx_clean`=1: pulse `false_start` and go to **HUNT**.
  - **RUN**:
    - Falling edges are ignored.
    - Each `baud_tick` increments the bit count (4-bit).
    - On the `baud_tick` where the count reaches 10 (the stop bit), go to **HUNT**.
- `frame_busy` = 1 in VERIFY and RUN, 0 in HUNT.
- When `enable`=0:
  - Prescaler and phase counter are held at 0 and the state is forced to HUNT.
  - History is preset to 3'b111, and `rx_clean` is forced to 1.
  - `baud_tick`, `frame_busy` and `false_start` are 0.
  - The synchroniser keeps running.
- Simultaneous events:
  - A falling edge on the same `sample_tick` as a phase-wrap `baud_tick` in HUNT: the edge wins. The phase is cleared and no `baud_tick` is issued that cycle.
  - In the RUN→HUNT transition cycle, an edge is not evaluated. The next start is detected from the following `sample_tick` onward.

## Timing
- Reset values: `rx_clean`=1, `baud_tick`=0, `frame_busy`=0, `false_start`=0, state=HUNT, all counters 0.
- `rst` mid-frame aborts immediately, with no `false_start` pulse.
- Latency from `rx_pin` to `rx_clean`: 2 clk (synchroniser) plus 2 `sample_tick` periods (majority), ±1 `sample_tick` period of quantisation.
- First `baud_tick` after the detected edge comes OVERSAMPLE/2 `sample_tick` periods later. Each subsequent tick follows every OVERSAMPLE `sample_tick` periods, exactly DIV·OVERSAMPLE clk apart.
- `frame_busy` rises in the clk after edge detection. It falls in the clk after the 10th `baud_tick`.
- `baud_tick` and `false_start` are registered and never longer than 1 clk.

## Test plan
All directed tests use CLK_HZ=1_600_000, BAUD=10_000 and OVERSAMPLE=16, giving DIV=10 and 160 clk per bit.
- **Reset**: assert `rst` asynchronously mid-clock → all outputs read 1/0/0/0 within the same cycle. After release with the line idle, `baud_tick` pulses every 160 clk.
- **Frame 0xA5** (LSB first, 160 clk/bit):
  - Exactly 10 `baud_tick` pulses are issued during `frame_busy`.
  - Each falls 80±10 clk after the corresponding bit edge plus the fixed filter delay.
  - `rx_clean` at the ticks reads 0,1,0,1,0,0,1,0,1,1.
- **Glitch rejection**: a 5-clk low pulse on an idle line gives `rx_clean` constantly 1, no state change and no `false_start`.
- **False start**: a 30-clk low pulse → `frame_busy` rises, `false_start` pulses once at the first `baud_tick`, and the state returns to HUNT with `frame_busy`=0.
- **Back-to-back frames 0x00 then 0xFF** with no idle gap → both frames are tracked. The second start edge realigns the phase, giving 20 `baud_tick`s total while `frame_busy`.
- **Enable / reset mid-frame**:
  - Drop `enable` after bit 4 → `baud_tick` stops in the next clk and `frame_busy`=0.
  - Re-enable and send 0x3C → the frame is tracked normally.
  - Repeat using `rst` instead of `enable` → same outcome.
